// File: rtl/fejkon_pcie_data_path.sv
// BAR0 single-DW memory TLP to CSR request bridge. Register read responses
// are returned on the TX stream as single-beat CplD TLPs.
package fejkon_pcie_data_path_pkg;

    localparam int unsigned ADDR_W = 62;
    localparam int unsigned DW_W   = 32;

    // Register-access request word
    typedef struct packed {
        logic [32:0]        rsvd;
        logic [ADDR_W-1:0]  addr;      // address[63:2]
        logic [DW_W-1:0]    payload;   // write data, or {8'h0, requester ID, tag}
        logic               is_write;
    } mem_req_t;

    // Register-access response word
    typedef struct packed {
        logic [63:0]        rsvd_hi;
        logic [DW_W-1:0]    data;
        logic [2:0]         rsvd_lo;
        logic [4:0]         lower_addr; // address[6:2]
        logic [15:0]        requester_id;
        logic [7:0]         tag;
    } mem_resp_t;

endpackage

module fejkon_pcie_data_path
    import fejkon_pcie_data_path_pkg::*;
(
    input  logic          clk,
    input  logic          reset,

    input  logic [255:0]  rx_st_data,
    input  logic [1:0]    rx_st_empty,
    input  logic          rx_st_error,
    input  logic          rx_st_startofpacket,
    input  logic          rx_st_endofpacket,
    input  logic          rx_st_valid,
    output logic          rx_st_ready,
    input  logic [7:0]    rx_st_bar,
    output logic          rx_st_mask,

    output logic [255:0]  tx_st_data,
    output logic          tx_st_startofpacket,
    output logic          tx_st_endofpacket,
    output logic          tx_st_valid,
    output logic [1:0]    tx_st_empty,
    output logic          tx_st_error,
    input  logic          tx_st_ready,

    input  logic [255:0]  data_tx_data,
    input  logic          data_tx_valid,
    input  logic          data_tx_startofpacket,
    input  logic          data_tx_endofpacket,
    input  logic [1:0]    data_tx_channel,
    input  logic [4:0]    data_tx_empty,
    output logic          data_tx_ready,

    output logic [127:0]  mem_access_req_data,
    output logic          mem_access_req_valid,
    input  logic          mem_access_req_ready,

    input  logic [127:0]  mem_access_resp_data,
    input  logic          mem_access_resp_valid,
    output logic          mem_access_resp_ready,

    input  logic [3:0]    tl_cfg_add,
    input  logic [31:0]   tl_cfg_ctl,
    input  logic [52:0]   tl_cfg_sts
);

    localparam logic [DW_W-1:0] CPLD_DW0      = 32'h4A00_0001;
    localparam logic [15:0]     CPLD_BYTE_CNT = 16'h0004;
    localparam logic [3:0]      CFG_ADD_ID    = 4'hF;

    logic [DW_W-1:0] hdr_dw2;
    logic [DW_W-1:0] hdr_dw3;
    logic [DW_W-1:0] hdr_dw4;
    logic [2:0]      tlp_fmt;
    logic [4:0]      tlp_type;
    logic [9:0]      tlp_len;
    logic [15:0]     rx_requester_id;
    logic [7:0]      rx_tag;

    logic            req_hit_c;
    mem_req_t        req_next_c;
    mem_resp_t       resp_c;
    logic            resp_fire_c;
    logic [255:0]    cpl_data_c;
    logic [1:0]      cpl_empty_c;
    logic [15:0]     completer_id;

    assign tlp_fmt         = rx_st_data[31:29];
    assign tlp_type        = rx_st_data[28:24];
    assign tlp_len         = rx_st_data[9:0];
    assign rx_requester_id = rx_st_data[63:48];
    assign rx_tag          = rx_st_data[47:40];
    assign hdr_dw2         = rx_st_data[95:64];
    assign hdr_dw3         = rx_st_data[127:96];
    assign hdr_dw4         = rx_st_data[159:128];

    assign rx_st_mask    = 1'b0;
    assign tx_st_error   = 1'b0;
    assign data_tx_ready = 1'b1;

    // Every beat is consumed whenever the request register can take a new word.
    assign rx_st_ready = !mem_access_req_valid || mem_access_req_ready;

    // Only single-beat, single-DW MRd/MWr (fmt 0xx, type 0) hitting BAR0 qualify.
    assign req_hit_c = rx_st_valid && rx_st_ready
                    && rx_st_startofpacket && rx_st_endofpacket
                    && !rx_st_error && rx_st_bar[0]
                    && (tlp_type == 5'h00) && !tlp_fmt[2]
                    && (tlp_len == 10'd1);

    always_comb begin : build_req
        req_next_c          = '0;
        req_next_c.is_write = tlp_fmt[1];
        if (tlp_fmt[0]) begin
            req_next_c.addr = {hdr_dw2, hdr_dw3[31:2]};
        end else begin
            req_next_c.addr = {32'h0, hdr_dw2[31:2]};
        end
        if (tlp_fmt[1]) begin
            // 3DW headers with a QW-unaligned address carry data in DW3
            if (!tlp_fmt[0] && hdr_dw2[2]) begin
                req_next_c.payload = hdr_dw3;
            end else begin
                req_next_c.payload = hdr_dw4;
            end
        end else begin
            req_next_c.payload = {8'h00, rx_requester_id, rx_tag};
        end
    end

    always_ff @(posedge clk or negedge reset) begin : req_reg
        if (!reset) begin
            mem_access_req_valid <= 1'b0;
            mem_access_req_data  <= '0;
        end else if (rx_st_ready) begin
            mem_access_req_valid <= req_hit_c;
            if (req_hit_c) begin
                mem_access_req_data <= req_next_c;
            end
        end
    end

    assign resp_c                = mem_access_resp_data;
    assign mem_access_resp_ready = !tx_st_valid || tx_st_ready;
    assign resp_fire_c           = mem_access_resp_valid && mem_access_resp_ready;

    always_comb begin : build_cpl
        cpl_data_c          = '0;
        cpl_empty_c         = 2'd1;
        cpl_data_c[31:0]    = CPLD_DW0;
        cpl_data_c[63:32]   = {completer_id, CPLD_BYTE_CNT};
        cpl_data_c[95:64]   = {resp_c.requester_id, resp_c.tag, 1'b0,
                               resp_c.lower_addr, 2'b00};
        // Payload sits in DW3 for QW-unaligned addresses, else DW4 after a zero DW3
        if (resp_c.lower_addr[0]) begin
            cpl_data_c[127:96]  = resp_c.data;
            cpl_empty_c         = 2'd2;
        end else begin
            cpl_data_c[159:128] = resp_c.data;
            cpl_empty_c         = 2'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin : tx_reg
        if (!reset) begin
            tx_st_valid         <= 1'b0;
            tx_st_data          <= '0;
            tx_st_empty         <= '0;
            tx_st_startofpacket <= 1'b0;
            tx_st_endofpacket   <= 1'b0;
        end else if (mem_access_resp_ready) begin
            tx_st_valid <= mem_access_resp_valid;
            if (resp_fire_c) begin
                tx_st_data          <= cpl_data_c;
                tx_st_empty         <= cpl_empty_c;
                tx_st_startofpacket <= 1'b1;
                tx_st_endofpacket   <= 1'b1;
            end
        end
    end

    // Completer ID = {bus, device, function 0} from the hard-IP config sideband
    always_ff @(posedge clk or negedge reset) begin : cfg_reg
        if (!reset) begin
            completer_id <= '0;
        end else if (tl_cfg_add == CFG_ADD_ID) begin
            completer_id <= {tl_cfg_ctl[12:5], tl_cfg_ctl[4:0], 3'b000};
        end
    end

    logic unused_inputs;
    assign unused_inputs = ^{rx_st_empty, rx_st_bar[7:1], rx_st_data[255:160],
                             rx_st_data[39:32], rx_st_data[23:10],
                             data_tx_data, data_tx_valid, data_tx_startofpacket,
                             data_tx_endofpacket, data_tx_channel, data_tx_empty,
                             tl_cfg_ctl[31:13], tl_cfg_sts,
                             resp_c.rsvd_hi, resp_c.rsvd_lo};

endmodule

// File: tb/tb_fejkon_pcie_data_path.sv
// Randomized bench for fejkon_pcie_data_path against a transaction-level model
// of the TLP-to-request and response-to-CplD rules.
module tb_fejkon_pcie_data_path;

    logic          clk = 1'b0;
    logic          reset;
    logic [255:0]  rx_st_data;
    logic [1:0]    rx_st_empty;
    logic          rx_st_error;
    logic          rx_st_startofpacket;
    logic          rx_st_endofpacket;
    logic          rx_st_valid;
    logic          rx_st_ready;
    logic [7:0]    rx_st_bar;
    logic          rx_st_mask;
    logic [255:0]  tx_st_data;
    logic          tx_st_startofpacket;
    logic          tx_st_endofpacket;
    logic          tx_st_valid;
    logic [1:0]    tx_st_empty;
    logic          tx_st_error;
    logic          tx_st_ready;
    logic [255:0]  data_tx_data;
    logic          data_tx_valid;
    logic          data_tx_startofpacket;
    logic          data_tx_endofpacket;
    logic [1:0]    data_tx_channel;
    logic [4:0]    data_tx_empty;
    logic          data_tx_ready;
    logic [127:0]  mem_access_req_data;
    logic          mem_access_req_valid;
    logic          mem_access_req_ready;
    logic [127:0]  mem_access_resp_data;
    logic          mem_access_resp_valid;
    logic          mem_access_resp_ready;
    logic [3:0]    tl_cfg_add;
    logic [31:0]   tl_cfg_ctl;
    logic [52:0]   tl_cfg_sts;

    always #5 clk = ~clk;

    fejkon_pcie_data_path dut (
        .clk                   (clk),
        .reset                 (reset),
        .rx_st_data            (rx_st_data),
        .rx_st_empty           (rx_st_empty),
        .rx_st_error           (rx_st_error),
        .rx_st_startofpacket   (rx_st_startofpacket),
        .rx_st_endofpacket     (rx_st_endofpacket),
        .rx_st_valid           (rx_st_valid),
        .rx_st_ready           (rx_st_ready),
        .rx_st_bar             (rx_st_bar),
        .rx_st_mask            (rx_st_mask),
        .tx_st_data            (tx_st_data),
        .tx_st_startofpacket   (tx_st_startofpacket),
        .tx_st_endofpacket     (tx_st_endofpacket),
        .tx_st_valid           (tx_st_valid),
        .tx_st_empty           (tx_st_empty),
        .tx_st_error           (tx_st_error),
        .tx_st_ready           (tx_st_ready),
        .data_tx_data          (data_tx_data),
        .data_tx_valid         (data_tx_valid),
        .data_tx_startofpacket (data_tx_startofpacket),
        .data_tx_endofpacket   (data_tx_endofpacket),
        .data_tx_channel       (data_tx_channel),
        .data_tx_empty         (data_tx_empty),
        .data_tx_ready         (data_tx_ready),
        .mem_access_req_data   (mem_access_req_data),
        .mem_access_req_valid  (mem_access_req_valid),
        .mem_access_req_ready  (mem_access_req_ready),
        .mem_access_resp_data  (mem_access_resp_data),
        .mem_access_resp_valid (mem_access_resp_valid),
        .mem_access_resp_ready (mem_access_resp_ready),
        .tl_cfg_add            (tl_cfg_add),
        .tl_cfg_ctl            (tl_cfg_ctl),
        .tl_cfg_sts            (tl_cfg_sts)
    );

    typedef struct {
        logic [255:0] data;
        logic [7:0]   bar;
        logic         sop;
        logic         eop;
        logic         err;
    } beat_t;

    int           n_compared   = 0;
    int           n_mismatched = 0;
    beat_t        beat_q[$];
    logic [127:0] exp_req[$];
    logic [127:0] pend_resp[$];
    logic [255:0] exp_cpl[$];
    logic [1:0]   exp_empty[$];
    logic [31:0]  mem_model [logic [61:0]];
    logic [15:0]  model_cid = 16'h0;
    int           rx_pct = 100, req_pct = 100, resp_pct = 100, tx_pct = 100;
    logic         cfg_rand = 1'b0;
    logic [3:0]   cfg_add  = 4'h0;
    logic [31:0]  cfg_ctl  = 32'h0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Build a one-beat TLP; unused DWs carry random junk.
    function automatic logic [255:0] mk_tlp(input logic [2:0] fmt, input logic [9:0] len,
                                            input logic [63:0] addr, input logic [15:0] rid,
                                            input logic [7:0] tag, input logic [31:0] data);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
        d[31:0]  = {fmt, 5'h00, 14'h0, len};
        d[63:32] = {rid, tag, 8'h0F};
        if (fmt[0]) begin
            d[95:64]   = addr[63:32];
            d[127:96]  = {addr[31:2], 2'b00};
            d[159:128] = data;
        end else begin
            d[95:64] = {addr[31:2], 2'b00};
            if (addr[2]) d[127:96]  = data;
            else         d[159:128] = data;
        end
        return d;
    endfunction

    function automatic beat_t good_beat(input logic [2:0] fmt, input logic [63:0] addr,
                                        input logic [15:0] rid, input logic [7:0] tag,
                                        input logic [31:0] data);
        beat_t b;
        b.data = mk_tlp(fmt, 10'd1, addr, rid, tag, data);
        b.bar  = 8'h01;
        b.sop  = 1'b1;
        b.eop  = 1'b1;
        b.err  = 1'b0;
        return b;
    endfunction

    // Expected request word for an accepted beat; returns 0 when the beat is dropped.
    function automatic logic expect_req(input beat_t b, output logic [127:0] w);
        logic [31:0] h0, h1, h2, h3, h4, pl;
        logic [61:0] a;
        logic        fourdw, wr;
        h0 = b.data[31:0];   h1 = b.data[63:32];  h2 = b.data[95:64];
        h3 = b.data[127:96]; h4 = b.data[159:128];
        w  = '0;
        if (!(b.sop && b.eop && !b.err && b.bar[0])) return 1'b0;
        if (h0[28:24] != 5'd0 || h0[9:0] != 10'd1) return 1'b0;
        if (h0[31:29] > 3'd3) return 1'b0;
        fourdw = (h0[31:29] == 3'd1) || (h0[31:29] == 3'd3);
        wr     = (h0[31:29] >= 3'd2);
        a      = fourdw ? {h2, h3[31:2]} : {32'h0, h2[31:2]};
        if (wr) pl = (!fourdw && h2[2]) ? h3 : h4;
        else    pl = {8'h00, h1[31:16], h1[15:8]};
        w = {33'h0, a, pl, wr};
        return 1'b1;
    endfunction

    function automatic logic [255:0] expect_cpl(input logic [127:0] r, input logic [15:0] cid,
                                                output logic [1:0] emp);
        logic [255:0] d;
        d          = '0;
        d[31:0]    = 32'h4A000001;
        d[63:32]   = {cid, 16'h0004};
        d[95:64]   = {r[23:8], r[7:0], 1'b0, r[28:24], 2'b00};
        if (r[24]) begin d[127:96]  = r[63:32]; emp = 2'd2; end
        else       begin d[159:128] = r[63:32]; emp = 2'd1; end
        return d;
    endfunction

    // CSR responder model: writes update memory, reads queue a response.
    task automatic respond(input logic [127:0] w);
        logic [61:0] a;
        logic [31:0] d;
        a = w[94:33];
        if (w[0]) begin
            mem_model[a] = w[32:1];
        end else begin
            if (!mem_model.exists(a)) mem_model[a] = $urandom;
            d = mem_model[a];
            pend_resp.push_back({32'($urandom), 32'($urandom), d, 3'($urandom),
                                 a[4:0], w[24:9], w[8:1]});
        end
    endtask

    task automatic cycle();
        logic         rx_acc, req_take, resp_acc, tx_take, exp_rx_rdy, exp_resp_rdy;
        logic [127:0] w;
        logic [255:0] c;
        logic [1:0]   e;
        beat_t        b;
        @(negedge clk);
        if (beat_q.size() != 0 && $urandom_range(99) < rx_pct) begin
            b                   = beat_q[0];
            rx_st_valid         = 1'b1;
            rx_st_data          = b.data;
            rx_st_bar           = b.bar;
            rx_st_startofpacket = b.sop;
            rx_st_endofpacket   = b.eop;
            rx_st_error         = b.err;
        end else begin
            rx_st_valid         = 1'b0;
            rx_st_data          = {8{$urandom}};
            rx_st_bar           = 8'h01;
            rx_st_startofpacket = 1'b1;
            rx_st_endofpacket   = 1'b1;
            rx_st_error         = 1'b0;
        end
        rx_st_empty          = 2'($urandom);
        mem_access_req_ready = ($urandom_range(99) < req_pct);
        tx_st_ready          = ($urandom_range(99) < tx_pct);
        if (pend_resp.size() != 0 && $urandom_range(99) < resp_pct) begin
            mem_access_resp_valid = 1'b1;
            mem_access_resp_data  = pend_resp[0];
        end else begin
            mem_access_resp_valid = 1'b0;
            mem_access_resp_data  = {4{$urandom}};
        end
        if (cfg_rand) begin
            tl_cfg_add = ($urandom_range(19) == 0) ? 4'hF : 4'($urandom_range(14));
            tl_cfg_ctl = $urandom;
        end else begin
            tl_cfg_add = cfg_add;
            tl_cfg_ctl = cfg_ctl;
        end
        #1;
        exp_rx_rdy   = (exp_req.size() == 0) || mem_access_req_ready;
        exp_resp_rdy = (exp_cpl.size() == 0) || tx_st_ready;
        check("req_valid", mem_access_req_valid, exp_req.size() != 0);
        if (mem_access_req_valid && exp_req.size() != 0)
            check("req_data", mem_access_req_data, exp_req[0]);
        check("tx_valid", tx_st_valid, exp_cpl.size() != 0);
        if (tx_st_valid && exp_cpl.size() != 0) begin
            check("tx_data", tx_st_data, exp_cpl[0]);
            check("tx_empty", tx_st_empty, exp_empty[0]);
            check("tx_sop_eop", {tx_st_startofpacket, tx_st_endofpacket}, 2'b11);
        end
        check("rx_ready", rx_st_ready, exp_rx_rdy);
        check("resp_ready", mem_access_resp_ready, exp_resp_rdy);

        rx_acc   = rx_st_valid && exp_rx_rdy;
        req_take = (exp_req.size() != 0) && mem_access_req_ready;
        resp_acc = mem_access_resp_valid && exp_resp_rdy;
        tx_take  = (exp_cpl.size() != 0) && tx_st_ready;
        if (tx_take) begin
            void'(exp_cpl.pop_front());
            void'(exp_empty.pop_front());
        end
        if (resp_acc) begin
            c = expect_cpl(pend_resp[0], model_cid, e);
            exp_cpl.push_back(c);
            exp_empty.push_back(e);
            void'(pend_resp.pop_front());
        end
        if (req_take) begin
            w = exp_req.pop_front();
            respond(w);
        end
        if (rx_acc) begin
            b = beat_q.pop_front();
            if (expect_req(b, w)) exp_req.push_back(w);
        end
        if (tl_cfg_add == 4'hF) model_cid = {tl_cfg_ctl[12:5], tl_cfg_ctl[4:0], 3'b000};
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain();
        int n = 0;
        while ((beat_q.size() != 0 || exp_req.size() != 0 || pend_resp.size() != 0 ||
                exp_cpl.size() != 0) && n < 3000) begin
            cycle();
            n++;
        end
        check("drain_done", n < 3000, 1'b1);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset                 = 1'b0;
        rx_st_valid           = 1'b0;
        mem_access_resp_valid = 1'b0;
        beat_q.delete();
        exp_req.delete();
        pend_resp.delete();
        exp_cpl.delete();
        exp_empty.delete();
        model_cid = 16'h0;
        @(negedge clk);
        #1;
        check("rst_req_valid", mem_access_req_valid, 1'b0);
        check("rst_tx_valid", tx_st_valid, 1'b0);
        check("rst_tx_data", tx_st_data, 256'h0);
        check("rst_tx_empty", tx_st_empty, 2'd0);
        check("rst_tx_sop_eop", {tx_st_startofpacket, tx_st_endofpacket}, 2'b00);
        check("const_outs", {rx_st_mask, tx_st_error, data_tx_ready}, 3'b001);
        reset = 1'b1;
    endtask

    function automatic beat_t rand_beat();
        beat_t       b;
        logic [63:0] a;
        a = {32'($urandom_range(1)), 32'($urandom_range(15) * 4)};
        b = good_beat(3'($urandom_range(3)), a, 16'($urandom), 8'($urandom), $urandom);
        case ($urandom_range(19))
            0: b.data[9:0]   = 10'($urandom_range(1023, 2));
            1: b.bar         = 8'($urandom) & 8'hFE;
            2: b.err         = 1'b1;
            3: b.eop         = 1'b0;
            4: b.sop         = 1'b0;
            5: b.data[28:24] = 5'($urandom_range(31, 1));
            6: b.data[31:29] = 3'($urandom_range(7, 4));
            default: ;
        endcase
        return b;
    endfunction

    initial begin
        beat_t b;
        reset = 1'b0;
        rx_st_data = '0; rx_st_empty = '0; rx_st_error = 1'b0;
        rx_st_startofpacket = 1'b0; rx_st_endofpacket = 1'b0; rx_st_valid = 1'b0;
        rx_st_bar = '0; tx_st_ready = 1'b1;
        data_tx_data = {8{$urandom}}; data_tx_valid = 1'b1; data_tx_startofpacket = 1'b1;
        data_tx_endofpacket = 1'b1; data_tx_channel = 2'd1; data_tx_empty = 5'd3;
        mem_access_req_ready = 1'b1; mem_access_resp_data = '0; mem_access_resp_valid = 1'b0;
        tl_cfg_add = 4'h0; tl_cfg_ctl = '0; tl_cfg_sts = {$urandom, 21'($urandom)};
        repeat (2) @(negedge clk);
        apply_reset();

        // Directed: completer ID, aligned/unaligned reads, write then read-back, drops
        mem_model[62'h0] = 32'h02010de5;
        mem_model[62'h1] = 32'hdeadbeef;
        cfg_add = 4'hF;
        cfg_ctl = 32'h0000_0062;
        cycle();
        cfg_add = 4'h0;
        beat_q.push_back(good_beat(3'b000, 64'h0,  16'h0100, 8'h05, $urandom));
        beat_q.push_back(good_beat(3'b000, 64'h4,  16'h0100, 8'h06, $urandom));
        beat_q.push_back(good_beat(3'b010, 64'h80, 16'h0100, 8'h07, 32'h12345678));
        beat_q.push_back(good_beat(3'b000, 64'h80, 16'h0100, 8'h08, $urandom));
        b = good_beat(3'b000, 64'h8, 16'h0100, 8'h09, $urandom);
        b.data[9:0] = 10'd2;
        beat_q.push_back(b);
        b = good_beat(3'b000, 64'hC, 16'h0100, 8'h0A, $urandom);
        b.bar = 8'h02;
        beat_q.push_back(b);
        b = good_beat(3'b010, 64'h10, 16'h0100, 8'h0B, $urandom);
        b.err = 1'b1;
        beat_q.push_back(b);
        drain();

        // Back-pressure on TX, then on the request side
        tx_pct = 0;
        beat_q.push_back(good_beat(3'b000, 64'h4, 16'h0200, 8'h11, $urandom));
        beat_q.push_back(good_beat(3'b001, 64'h1_0000_0000, 16'h0200, 8'h12, $urandom));
        run(12);
        tx_pct  = 100;
        req_pct = 0;
        beat_q.push_back(good_beat(3'b011, 64'h1_0000_0008, 16'h0300, 8'h13, $urandom));
        beat_q.push_back(good_beat(3'b010, 64'h24, 16'h0300, 8'h14, $urandom));
        run(8);
        req_pct = 100;
        drain();

        // Randomized traffic with random handshakes and config updates
        cfg_rand = 1'b1;
        for (int chunk = 0; chunk < 8; chunk++) begin
            rx_pct   = (chunk == 0) ? 100 : int'($urandom_range(100, 30));
            req_pct  = (chunk == 0) ? 100 : int'($urandom_range(100, 30));
            resp_pct = (chunk == 0) ? 100 : int'($urandom_range(100, 30));
            tx_pct   = (chunk == 0) ? 100 : int'($urandom_range(100, 30));
            for (int i = 0; i < 60; i++) beat_q.push_back(rand_beat());
            drain();
        end

        // Reset in the middle of pending traffic
        rx_pct = 100; req_pct = 100; resp_pct = 100; tx_pct = 0;
        for (int i = 0; i < 6; i++) beat_q.push_back(rand_beat());
        run(6);
        apply_reset();
        cfg_rand = 1'b0;
        tx_pct   = 100;
        for (int i = 0; i < 20; i++) beat_q.push_back(rand_beat());
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
